// File: rtl/trap_filter_cfg.sv
// Runtime-configurable K/L/M trapezoidal shaper for one ADC channel.
// Delay-line taps feed a 5-stage pipeline: difference, pole-zero, double accumulation, saturation.
module trap_filter_cfg #(
    parameter int DATA_W    = 12,
    parameter int OUT_W     = 16,
    parameter int MAX_DEPTH = 64,
    parameter int M_W       = 10,
    parameter int ACC_W     = 32,
    parameter int K_DEF     = 2,
    parameter int L_DEF     = 4,
    parameter int M_DEF     = 0,
    parameter int SHIFT_DEF = 4,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic                     cfg_load,
    input  logic [DEPTH_W-1:0]       cfg_k,
    input  logic [DEPTH_W-1:0]       cfg_l,
    input  logic [M_W-1:0]           cfg_m,
    input  logic [4:0]               cfg_shift,
    output logic                     cfg_ack,
    output logic                     cfg_err,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  output_data,
    output logic                     overflow
);

    typedef enum logic {S_FLUSH, S_RUN} state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
    localparam logic [DEPTH_W:0]        SUM_MAX = (DEPTH_W + 1)'(MAX_DEPTH - 1);

    // Control state
    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0]   k_q, k_d, l_q, l_d;
    logic [M_W-1:0]       m_q, m_d;
    logic [4:0]           shift_q, shift_d;
    logic                 ack_q, ack_d, err_q, err_d;

    // Datapath state
    logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d_q, d_d;
    logic signed [ACC_W-1:0] p_q, p_d, md_q, md_d, r_q, r_d, s_q, s_d;
    logic [4:0]              v_q, v_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;

    // Delay buffer and its write port
    logic signed [DATA_W-1:0] mem_q [MAX_DEPTH];
    logic                     mem_we;
    logic [DEPTH_W-1:0]       mem_waddr;
    logic signed [DATA_W-1:0] mem_wdata;

    logic accept, cfg_accept, pipe_clear, cfg_ok;
    logic [DEPTH_W:0] kl_sum;

    assign kl_sum = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign cfg_ok = (cfg_k != '0) && (cfg_k <= cfg_l) && (kl_sum <= SUM_MAX);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        l_d         = l_q;
        m_d         = m_q;
        shift_d     = shift_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        accept      = 1'b0;
        cfg_accept  = 1'b0;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = input_data;
        case (state_q)
            S_FLUSH: begin
                mem_we      = 1'b1;
                mem_waddr   = flush_cnt_q;
                mem_wdata   = '0;
                flush_cnt_d = flush_cnt_q + 1'b1;
                wr_ptr_d    = '0;
                if (flush_cnt_q == DEPTH_W'(MAX_DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = !cfg_load;
                if (cfg_load) begin
                    if (cfg_ok) begin
                        cfg_accept  = 1'b1;
                        ack_d       = 1'b1;
                        k_d         = cfg_k;
                        l_d         = cfg_l;
                        m_d         = cfg_m;
                        shift_d     = cfg_shift;
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (in_valid) begin
                    accept   = 1'b1;
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    assign pipe_clear = (state_q == S_FLUSH) || cfg_accept;

    logic signed [ACC_W-1:0] x_ext, xk_ext, xl_ext, xkl_ext, m_ext, s_shr;

    // Taps are read before this cycle's write lands, so x[n-K] etc. never alias x[n].
    always_comb begin
        x_ext   = ACC_W'(input_data);
        xk_ext  = ACC_W'(mem_q[wr_ptr_q - k_q]);
        xl_ext  = ACC_W'(mem_q[wr_ptr_q - l_q]);
        xkl_ext = ACC_W'(mem_q[wr_ptr_q - k_q - l_q]);
        m_ext   = $signed({{(ACC_W - M_W){1'b0}}, m_q});
        s_shr   = s_q >>> shift_q;

        d1_d        = d1_q;
        d2_d        = d2_q;
        d_d         = d_q;
        p_d         = p_q;
        md_d        = md_q;
        r_d         = r_q;
        s_d         = s_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        v_d         = {v_q[3:0], accept};

        if (accept) begin
            d1_d = x_ext - xk_ext;
            d2_d = xl_ext - xkl_ext;
        end
        if (v_q[0]) d_d = d1_q - d2_q;
        if (v_q[1]) begin
            p_d  = p_q + d_q;
            md_d = m_ext * d_q;
        end
        if (v_q[2]) r_d = p_q + md_q;
        if (v_q[3]) s_d = s_q + r_q;
        if (v_q[4]) begin
            out_valid_d = 1'b1;
            if (s_shr > SAT_HI) begin
                out_d = SAT_HI[OUT_W-1:0];
                ovf_d = 1'b1;
            end else if (s_shr < SAT_LO) begin
                out_d = SAT_LO[OUT_W-1:0];
                ovf_d = 1'b1;
            end else begin
                out_d = s_shr[OUT_W-1:0];
            end
        end

        // A flush discards every in-flight sample and restarts both integrators from zero.
        if (pipe_clear) begin
            v_d         = '0;
            p_d         = '0;
            s_d         = '0;
            out_d       = out_q;
            out_valid_d = 1'b0;
            ovf_d       = cfg_accept ? 1'b0 : ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            wr_ptr_q    <= '0;
            k_q         <= DEPTH_W'(K_DEF);
            l_q         <= DEPTH_W'(L_DEF);
            m_q         <= M_W'(M_DEF);
            shift_q     <= 5'(SHIFT_DEF);
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            d_q         <= '0;
            p_q         <= '0;
            md_q        <= '0;
            r_q         <= '0;
            s_q         <= '0;
            v_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            l_q         <= l_d;
            m_q         <= m_d;
            shift_q     <= shift_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d_q         <= d_d;
            p_q         <= p_d;
            md_q        <= md_d;
            r_q         <= r_d;
            s_q         <= s_d;
            v_q         <= v_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cfg_ack     = ack_q;
    assign cfg_err     = err_q;
    assign out_valid   = out_valid_q;
    assign output_data = out_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_trap_filter_cfg.sv
// Randomized bench for trap_filter_cfg against a sample-history model of the trapezoid equations.
module tb_trap_filter_cfg;
    localparam int DATA_W  = 12;
    localparam int OUT_W   = 16;
    localparam int DEPTH_W = 6;
    localparam int M_W     = 10;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] input_data = '0;
    logic                     cfg_load = 1'b0;
    logic [DEPTH_W-1:0]       cfg_k = '0;
    logic [DEPTH_W-1:0]       cfg_l = '0;
    logic [M_W-1:0]           cfg_m = '0;
    logic [4:0]               cfg_shift = '0;
    logic                     cfg_ack, cfg_err, out_valid, overflow;
    logic signed [OUT_W-1:0]  output_data;

    trap_filter_cfg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .input_data(input_data), .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l),
        .cfg_m(cfg_m), .cfg_shift(cfg_shift), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .out_valid(out_valid), .output_data(output_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: accepted-sample history, configuration, integrators, expected outputs.
    typedef struct { int val; bit sat; longint due; } exp_t;
    exp_t   expq[$];
    int     hist[$];
    int     obs[$];
    int     mk = 2, ml = 4, mm = 0, msh = 4;
    int     mp = 0, ms = 0;
    bit     movf = 1'b0;

    function automatic int tap(input int j);
        if (j < hist.size()) return hist[hist.size() - 1 - j];
        return 0;
    endfunction

    task automatic model_accept(input int x);
        int d, r, sh;
        exp_t e;
        hist.push_back(x);
        d  = (tap(0) - tap(mk)) - (tap(ml) - tap(mk + ml));
        mp = mp + d;
        r  = mp + mm * d;
        ms = ms + r;
        sh = ms >>> msh;
        e.sat = 1'b0;
        if (sh > 32767) begin sh = 32767; e.sat = 1'b1; end
        else if (sh < -32768) begin sh = -32768; e.sat = 1'b1; end
        e.val = sh;
        e.due = cyc + 6;
        expq.push_back(e);
    endtask

    task automatic model_flush();
        hist.delete();
        expq.delete();
        mp = 0;
        ms = 0;
    endtask

    task automatic monitor();
        exp_t e;
        if (expq.size() > 0 && cyc > expq[0].due) begin
            check_val("out_missing", cyc, expq[0].due);
            void'(expq.pop_front());
        end
        if (out_valid) begin
            $display("OUT cyc=%0d data=%0d ovf=%0d", cyc, output_data, overflow);
            obs.push_back(int'(output_data));
            if (expq.size() == 0) begin
                check_val("out_unexpected", 1, 0);
            end else begin
                e = expq.pop_front();
                movf = movf | e.sat;
                check_val("out_data", output_data, e.val);
                check_val("out_latency", cyc, e.due);
                check_val("overflow", overflow, movf);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic drive_sample(input int x, input bit valid);
        @(posedge clk);
        #1;
        in_valid   = valid;
        input_data = DATA_W'(x);
        tick();
        if (in_valid && in_ready) model_accept(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_sample(0, 1'b0);
    endtask

    task automatic wait_ready(input bit after_reset);
        int n;
        n = 0;
        tick();
        while (!in_ready && n < 1000) begin
            if (after_reset && n == 10) check_val("flush_out_zero", output_data, 0);
            n++;
            tick();
        end
        check_val("flush_cycles", n, 64);
    endtask

    task automatic do_cfg(input int k, input int l, input int m, input int sh,
                          input bit offer, input int x);
        bit ok;
        ok = (k >= 1) && (k <= l) && (k + l <= 63);
        @(posedge clk);
        #1;
        cfg_load   = 1'b1;
        cfg_k      = DEPTH_W'(k);
        cfg_l      = DEPTH_W'(l);
        cfg_m      = M_W'(m);
        cfg_shift  = 5'(sh);
        in_valid   = offer;
        input_data = DATA_W'(x);
        tick();
        check_val("cfg_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        $display("CFG k=%0d l=%0d m=%0d shift=%0d ack=%0d err=%0d", k, l, m, sh, cfg_ack, cfg_err);
        check_val("cfg_ack", cfg_ack, ok);
        check_val("cfg_err", cfg_err, !ok);
        if (ok) begin
            mk = k; ml = l; mm = m; msh = sh;
            model_flush();
            movf = 1'b0;
            check_val("cfg_ovf_clear", overflow, 0);
            wait_ready(1'b0);
        end else begin
            tick();
            check_val("err_ready_back", in_ready, 1);
        end
    endtask

    task automatic check_seq(input string tag, input int exp_vals[8], input int n);
        check_val({tag, "_count"}, obs.size() >= n, 1);
        for (int i = 0; i < n && i < obs.size(); i++) check_val(tag, obs[i], exp_vals[i]);
    endtask

    int step_exp[8]    = '{1, 3, 5, 7, 8, 8, 8, 8};
    int impulse_exp[8] = '{32, 16, -16, 0, 0, 0, 0, 0};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_output", output_data, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_ack", cfg_ack, 0);
        check_val("rst_err", cfg_err, 0);
        check_val("rst_ovf", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ready(1'b1);

        // Step of 16 with default K=2 L=4 M=0 shift=4, continuous
        do_cfg(2, 4, 0, 4, 1'b0, 0);
        obs.delete();
        for (int i = 0; i < 12; i++) drive_sample(16, 1'b1);
        idle(8);
        check_seq("step_cont", step_exp, 8);

        // Same step with random in_valid gaps
        do_cfg(2, 4, 0, 4, 1'b0, 0);
        obs.delete();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            drive_sample(16, 1'b1);
        end
        idle(8);
        check_seq("step_gaps", step_exp, 8);

        // Impulse with pole-zero M=1
        do_cfg(1, 2, 1, 0, 1'b0, 0);
        obs.delete();
        drive_sample(16, 1'b1);
        for (int i = 0; i < 6; i++) drive_sample(0, 1'b1);
        idle(8);
        check_seq("impulse", impulse_exp, 5);

        // Invalid configs mid-stream; offered sample must be dropped
        for (int i = 0; i < 6; i++) drive_sample($urandom_range(0, 200) - 100, 1'b1);
        do_cfg(0, 3, 0, 0, 1'b1, 777);
        for (int i = 0; i < 4; i++) drive_sample($urandom_range(0, 200) - 100, 1'b1);
        do_cfg(5, 3, 0, 0, 1'b1, -500);
        for (int i = 0; i < 6; i++) drive_sample($urandom_range(0, 200) - 100, 1'b1);
        idle(8);

        // Saturation and sticky overflow
        do_cfg(31, 31, 0, 0, 1'b0, 0);
        for (int i = 0; i < 80; i++) drive_sample(2047, 1'b1);
        idle(8);
        check_val("sat_hi", obs[obs.size() - 1], 32767);
        check_val("ovf_sticky", overflow, 1);
        for (int i = 0; i < 80; i++) drive_sample(-2048, 1'b1);
        idle(8);
        check_val("sat_lo", obs[obs.size() - 1], -32768);
        check_val("ovf_held", overflow, 1);

        // Valid config with samples in flight: results discarded, overflow cleared
        for (int i = 0; i < 3; i++) drive_sample(1000, 1'b1);
        do_cfg(2, 4, 0, 4, 1'b1, 5);
        idle(8);

        // Randomized configs and streams
        for (int round = 0; round < 8; round++) begin
            int k, l;
            k = $urandom_range(1, 31);
            l = $urandom_range(k, 63 - k);
            do_cfg(k, l, $urandom_range(0, 1023), $urandom_range(0, 31), 1'b0, 0);
            for (int i = 0; i < 70; i++) begin
                drive_sample($urandom_range(0, 4095) - 2048, $urandom_range(0, 9) < 7);
                if (i == 35) do_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1023),
                                    $urandom_range(0, 31), 1'b1, 1);
            end
            idle(8);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) drive_sample(1500, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_output", output_data, 0);
        check_val("arst_in_ready", in_ready, 0);
        check_val("arst_ovf", overflow, 0);
        in_valid = 1'b0;
        mk = 2; ml = 4; mm = 0; msh = 4;
        model_flush();
        movf = 1'b0;
        repeat (2) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ready(1'b1);
        obs.delete();
        for (int i = 0; i < 12; i++) drive_sample(16, 1'b1);
        idle(8);
        check_seq("step_after_rst", step_exp, 8);

        check_val("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
